mips_stage_controller: RTL
==========================

Name: mips_stage_controller

Overview:
- Multi-cycle sequencer for the single-issue MIPS datapath (fetch, decode, alu, memory, writeBack units).
- Replaces the free-running stage counter in mipsProcessor: owns the PC, drives the stage code every unit keys on, and skips the memory stage for non-memory instructions.
- Stalls in the memory stage on a ready handshake, resolves branches, halts on endProgram.
- Sits at the top level beside the datapath units; the units keep their existing stage-code input.

Parameters:
PC_W, 4, width of the instruction-index program counter
PROG_LEN, 9, number of instruction slots; PC wraps modulo PROG_LEN (2 to 2**PC_W)
PC_RESET, 0, PC value after reset
SKIP_MEM, 1, 1 = bypass MEMORY when neither mem_read nor mem_write; 0 = always visit MEMORY

Ports:
clock  in  1  system clock, all state on posedge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; leaves IDLE
branch  in  1  decode control: instruction is a conditional branch
zero  in  1  alu zero flag
mem_read  in  1  decode control
mem_write  in  1  decode control
mem_ready  in  1  memory completes the current access
end_program  in  1  decode control: halt after this instruction
branch_offset  in  PC_W  two's-complement instruction offset, relative to pc+1
stage  out  3  0 fetch, 1 decode, 2 alu, 3 memory, 4 writeback
stage_valid  out  1  high in FETCH through WRITEBACK
pc  out  PC_W  current instruction index
mem_req  out  1  high throughout MEMORY
halted  out  1  high in HALT
retired_count  out  16  instructions completed, saturating

Behaviour:
- reset low, at any time including mid-instruction or in HALT: state IDLE, pc=PC_RESET, stage=0, stage_valid=0, mem_req=0, halted=0, retired_count=0, branch_taken=0. Outputs are cleared asynchronously.
- Outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- IDLE: stage_valid=0. start=1 moves to FETCH on the next edge. start is ignored in every other state.
- FETCH -> DECODE -> EXECUTE: one cycle each.
- EXECUTE exit:
  - latch branch_taken = branch & zero.
  - next state is MEMORY if (mem_read | mem_write) or SKIP_MEM=0; otherwise WRITEBACK.
- MEMORY:
  - mem_req=1, stage=3.
  - Stays while mem_ready=0 (unbounded stall).
  - mem_ready=1 moves to WRITEBACK next edge; entry cycle counts, so minimum residency is 1 cycle.
  - mem_ready outside MEMORY is ignored.
- WRITEBACK: one cycle. At exit, retired_count increments, holding at 0xFFFF. Then:
  - end_program=1 -> HALT; pc unchanged.
  - else if branch_taken -> pc = wrap(pc + 1 + sext(branch_offset)), then FETCH.
  - else pc = wrap(pc + 1), then FETCH.
- wrap(x): computed signed in PC_W+2 bits. If x >= PROG_LEN subtract PROG_LEN; if x < 0 add PROG_LEN. Single correction step; |offset| < PROG_LEN is guaranteed by the toolchain. Example: pc=8, PROG_LEN=9 -> 0.
- end_program has priority over a taken branch in the same instruction.
- HALT: halted=1, stage_valid=0, stage=0. Absorbing until reset.
- Latency with no stalls: 4 cycles per non-memory instruction, 5 per memory instruction, plus mem_ready wait cycles.

Decomposition:
- Package mips_ctrl_pkg:
  - state enum IDLE/FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/HALT.
  - stage-code constants STAGE_FETCH=0 .. STAGE_WB=4, shared with the datapath units.
  - RETIRE_MAX=16'hFFFF.
- Sub-module mips_pc_next: combinational next-PC with sign extension and modulo wrap. Parameters PC_W and PROG_LEN; inputs pc, taken, offset; output next_pc.

Test Plan:
- Reset, pulse start, non-memory instruction (mem_read=mem_write=0, branch=0) -> stage 0,1,2,4 on consecutive cycles, pc 0->1 at WRITEBACK exit, retired_count=1.
- mem_read=1, mem_ready held low 3 cycles then high -> mem_req high for 4 cycles, stage=3 for 4 cycles, then stage=4; SKIP_MEM=0 variant -> stage=3 visited even with no access.
- pc=8, PROG_LEN=9, no branch -> pc=0. Branch taken at pc=2 with offset=-3 -> pc=0. Branch taken at pc=7 with offset=+3 -> pc=2. branch=1, zero=0 at pc=2 -> pc=3.
- end_program=1 together with a taken branch at pc=5 -> HALT, halted=1, pc stays 5, later start pulses ignored.
- reset asserted mid-MEMORY stall -> all outputs return to reset values immediately; start then restarts from pc=0.
- Force retired_count to 0xFFFE, retire 3 instructions -> 0xFFFF and held.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS stage sequencer.
// Stage codes are also consumed by the datapath units.
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXECUTE,
        MEMORY,
        WRITEBACK,
        HALT
    } state_t;

    localparam logic [2:0] STAGE_FETCH  = 3'd0;
    localparam logic [2:0] STAGE_DECODE = 3'd1;
    localparam logic [2:0] STAGE_ALU    = 3'd2;
    localparam logic [2:0] STAGE_MEM    = 3'd3;
    localparam logic [2:0] STAGE_WB     = 3'd4;

    localparam logic [15:0] RETIRE_MAX = 16'hFFFF;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == RETIRE_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mips_stage_controller_if.sv
// Control/status bundle between decode/alu/memory and the sequencer.
// master = sequencer side, slave = datapath side.
interface mips_stage_controller_if #(
    parameter int PC_W = 4
);
    logic            start;
    logic            branch;
    logic            zero;
    logic            mem_read;
    logic            mem_write;
    logic            mem_ready;
    logic            end_program;
    logic [PC_W-1:0] branch_offset;

    logic [2:0]      stage;
    logic            stage_valid;
    logic [PC_W-1:0] pc;
    logic            mem_req;
    logic            halted;
    logic [15:0]     retired_count;

    modport master (
        input  start, branch, zero,
        input  mem_read, mem_write, mem_ready,
        input  end_program, branch_offset,
        output stage, stage_valid, pc,
        output mem_req, halted, retired_count
    );

    modport slave (
        output start, branch, zero,
        output mem_read, mem_write, mem_ready,
        output end_program, branch_offset,
        input  stage, stage_valid, pc,
        input  mem_req, halted, retired_count
    );
endinterface

// File: rtl/mips_pc_next.sv
// Next instruction index: pc+1 (+offset when taken),
// folded back into 0..PROG_LEN-1 with one correction step.
module mips_pc_next #(
    parameter int PC_W     = 4,
    parameter int PROG_LEN = 9
) (
    input  logic [PC_W-1:0] pc,
    input  logic            taken,
    input  logic [PC_W-1:0] offset,
    output logic [PC_W-1:0] next_pc
);
    localparam int XW = PC_W + 2;
    localparam logic signed [XW-1:0] LEN = XW'(PROG_LEN);

    logic signed [XW-1:0] sum;
    logic signed [XW-1:0] fixed;
    logic signed [XW-1:0] off_x;

    // Two extra bits hold both the overflow past PROG_LEN and a sign.
    always_comb begin
        off_x = {{2{offset[PC_W-1]}}, offset};
        sum   = {2'b00, pc} + XW'(1);
        if (taken) begin
            sum = sum + off_x;
        end
        fixed = sum;
        if (sum[XW-1]) begin
            fixed = sum + LEN;
        end else if (sum >= LEN) begin
            fixed = sum - LEN;
        end
        next_pc = fixed[PC_W-1:0];
    end
endmodule

// File: rtl/mips_stage_controller.sv
// Multi-cycle stage sequencer: owns the PC, drives the stage code,
// stalls on mem_ready, resolves branches and halts on end_program.
module mips_stage_controller
    import mips_ctrl_pkg::*;
#(
    parameter int              PC_W     = 4,
    parameter int              PROG_LEN = 9,
    parameter logic [PC_W-1:0] PC_RESET = '0,
    parameter int              SKIP_MEM = 1
) (
    input logic                    clock,
    input logic                    reset,
    mips_stage_controller_if.master bus
);
    state_t          state_q;
    state_t          state_d;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_nxt;
    logic [15:0]     retired_q;
    logic            taken_q;
    logic            need_mem;

    logic [2:0]      stage_c;
    logic            valid_c;
    logic            mem_req_c;
    logic            halted_c;

    assign need_mem = bus.mem_read | bus.mem_write | (SKIP_MEM == 0);

    mips_pc_next #(
        .PC_W     (PC_W),
        .PROG_LEN (PROG_LEN)
    ) u_pc_next (
        .pc      (pc_q),
        .taken   (taken_q),
        .offset  (bus.branch_offset),
        .next_pc (pc_nxt)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus stage outputs decoded from the current state only.
    always_comb begin
        state_d   = state_q;
        stage_c   = STAGE_FETCH;
        valid_c   = 1'b0;
        mem_req_c = 1'b0;
        halted_c  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) state_d = FETCH;
            end
            FETCH: begin
                valid_c = 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                valid_c = 1'b1;
                stage_c = STAGE_DECODE;
                state_d = EXECUTE;
            end
            EXECUTE: begin
                valid_c = 1'b1;
                stage_c = STAGE_ALU;
                state_d = need_mem ? MEMORY : WRITEBACK;
            end
            MEMORY: begin
                valid_c   = 1'b1;
                mem_req_c = 1'b1;
                stage_c   = STAGE_MEM;
                if (bus.mem_ready) state_d = WRITEBACK;
            end
            WRITEBACK: begin
                valid_c = 1'b1;
                stage_c = STAGE_WB;
                state_d = bus.end_program ? HALT : FETCH;
            end
            HALT: begin
                halted_c = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // PC, branch decision and retire counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q      <= PC_RESET;
            retired_q <= '0;
            taken_q   <= 1'b0;
        end else begin
            if (state_q == EXECUTE) begin
                taken_q <= bus.branch & bus.zero;
            end
            if (state_q == WRITEBACK) begin
                retired_q <= sat_inc(retired_q);
                if (!bus.end_program) pc_q <= pc_nxt;
            end
        end
    end

    assign bus.stage         = stage_c;
    assign bus.stage_valid   = valid_c;
    assign bus.mem_req       = mem_req_c;
    assign bus.halted        = halted_c;
    assign bus.pc            = pc_q;
    assign bus.retired_count = retired_q;
endmodule
